// File: rtl/parking_lane_arbiter_if.sv
// rtl/parking_lane_arbiter_if.sv - lane sensors/keypads and gate/alarm signals of the entry arbiter
interface parking_lane_arbiter_if;
  logic [1:0]  arrival;
  logic [15:0] code0;
  logic [15:0] code1;
  logic [1:0]  code_ack;
  logic        vehicle_left;
  logic [1:0]  grant;
  logic        gate_open;
  logic        pin_error;
  logic        lock_alarm;
  logic        block_alarm;

  modport master (
    output arrival, code0, code1, code_ack, vehicle_left,
    input  grant, gate_open, pin_error, lock_alarm, block_alarm
  );

  modport slave (
    input  arrival, code0, code1, code_ack, vehicle_left,
    output grant, gate_open, pin_error, lock_alarm, block_alarm
  );
endinterface

// File: rtl/parking_lane_arbiter.sv
// rtl/parking_lane_arbiter.sv - round-robin two-lane entry arbiter with shared PIN check and gate
module parking_lane_arbiter #(
  parameter logic [15:0] PASSWORD     = 16'h5990,
  parameter int          MAX_TRIES    = 3,
  parameter int          GATE_TIMEOUT = 32
) (
  input logic                  clk,
  input logic                  rst,
  parking_lane_arbiter_if.slave bus
);

  localparam int TW = $clog2(GATE_TIMEOUT + 1);
  localparam logic [3:0]    TRIES_LIMIT = 4'(MAX_TRIES);
  localparam logic [TW-1:0] TMR_LAST    = TW'(GATE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    OPEN   = 3'd2,
    LOCKED = 3'd3,
    BLOCK  = 3'd4
  } state_t;

  state_t        state;
  logic [3:0]    attempts;
  logic [TW-1:0] tmr;
  logic          last_lane;
  logic          sel;
  logic [1:0]    ack_prev;
  logic          vl_prev;

  logic [1:0]    grant_q;
  logic          gate_q;
  logic          pin_q;
  logic          lock_q;
  logic          block_q;

  logic [1:0]    ack_rise;
  logic          vl_rise;
  logic          sel_ack;
  logic          sel_arrival;
  logic [15:0]   sel_code;
  logic          pick;

  always_comb begin
    ack_rise    = bus.code_ack & ~ack_prev;
    vl_rise     = bus.vehicle_left & ~vl_prev;
    sel_ack     = sel ? ack_rise[1] : ack_rise[0];
    sel_arrival = sel ? bus.arrival[1] : bus.arrival[0];
    sel_code    = sel ? bus.code1 : bus.code0;
    // With both lanes waiting, serve the one that did not go last.
    pick        = (bus.arrival == 2'b11) ? ~last_lane : bus.arrival[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      attempts  <= 4'd0;
      tmr       <= '0;
      last_lane <= 1'b1;
      sel       <= 1'b0;
      ack_prev  <= 2'b00;
      vl_prev   <= 1'b1;
      grant_q   <= 2'b00;
      gate_q    <= 1'b0;
      pin_q     <= 1'b0;
      lock_q    <= 1'b0;
      block_q   <= 1'b0;
    end else begin
      ack_prev <= bus.code_ack;
      vl_prev  <= bus.vehicle_left;
      pin_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.arrival) begin
            sel       <= pick;
            last_lane <= pick;
            grant_q   <= pick ? 2'b10 : 2'b01;
            attempts  <= 4'd0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          // An ack edge wins over a same-cycle arrival drop; the drop is seen next cycle.
          if (sel_ack) begin
            if (sel_code == PASSWORD) begin
              attempts <= 4'd0;
              tmr      <= '0;
              gate_q   <= 1'b1;
              state    <= OPEN;
            end else begin
              pin_q    <= 1'b1;
              attempts <= attempts + 4'd1;
              if (attempts + 4'd1 == TRIES_LIMIT) begin
                lock_q <= 1'b1;
                state  <= LOCKED;
              end
            end
          end else if (!sel_arrival) begin
            attempts <= 4'd0;
            grant_q  <= 2'b00;
            state    <= IDLE;
          end
        end
        OPEN: begin
          if (vl_rise) begin
            gate_q <= 1'b0;
            if (sel_arrival) begin
              block_q <= 1'b1;
              state   <= BLOCK;
            end else begin
              grant_q  <= 2'b00;
              attempts <= 4'd0;
              state    <= IDLE;
            end
          end else if (tmr == TMR_LAST) begin
            gate_q   <= 1'b0;
            grant_q  <= 2'b00;
            attempts <= 4'd0;
            state    <= IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        LOCKED: ;
        BLOCK:  ;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.gate_open   = gate_q;
  assign bus.pin_error   = pin_q;
  assign bus.lock_alarm  = lock_q;
  assign bus.block_alarm = block_q;

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// tb/tb_parking_lane_arbiter.sv - scoreboard bench for parking_lane_arbiter
module tb_parking_lane_arbiter;
  localparam int GT = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parking_lane_arbiter_if bus();

  parking_lane_arbiter #(
    .PASSWORD(16'h5990),
    .MAX_TRIES(3),
    .GATE_TIMEOUT(GT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int         at;
    logic [5:0] v;
  } exp_t;

  exp_t q[$];

  function automatic logic [5:0] outs();
    return {bus.grant, bus.gate_open, bus.pin_error, bus.lock_alarm, bus.block_alarm};
  endfunction

  // {grant, gate_open, pin_error, lock_alarm, block_alarm}
  function automatic logic [5:0] o(logic [1:0] g, logic go, logic pe, logic la, logic ba);
    return {g, go, pe, la, ba};
  endfunction

  task automatic expect_at(int dly, logic [5:0] v);
    exp_t e;
    e.at = cyc + dly;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_code(int lane, logic [15:0] code);
    if (lane == 0) bus.code0 = code; else bus.code1 = code;
    bus.code_ack[lane] = 1'b1;
    tick();
    bus.code_ack[lane] = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    expect_at(1, 6'b0);
    #1;
    total++;
    if (outs() !== 6'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", outs(), 6'b0);
    end
    bus.arrival      = 2'b00;
    bus.code_ack     = 2'b00;
    bus.vehicle_left = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  // Monitor: every change of the output vector is one presented response.
  initial begin
    logic [5:0] prev;
    logic [5:0] cur;
    exp_t       e;
    prev = 6'b0;
    forever begin
      @(negedge clk);
      cur = outs();
      if (cur !== prev) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change got=%b at cyc %0d, want no change", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.v || cyc != e.at) begin
            bad++;
            $display("FAIL out_event got=%b at cyc %0d, want=%b at cyc %0d", cur, cyc, e.v, e.at);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    bus.arrival      = 2'b00;
    bus.code0        = 16'h0000;
    bus.code1        = 16'h0000;
    bus.code_ack     = 2'b00;
    bus.vehicle_left = 1'b0;
    #1;
    total++;
    if (outs() !== 6'b0) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", outs(), 6'b0);
    end
    tick(2);
    rst = 1'b1;
    tick(2);

    // Basic entry on lane 0
    bus.arrival = 2'b01;
    expect_at(1, o(2'b01, 1, 0, 0, 0) & 6'b110000);
    tick();
    expect_at(1, o(2'b01, 1, 0, 0, 0));
    ack_code(0, 16'h5990);
    bus.arrival      = 2'b00;
    bus.vehicle_left = 1'b1;
    expect_at(1, o(2'b00, 0, 0, 0, 0));
    tick();
    bus.vehicle_left = 1'b0;
    tick(2);

    // Two wrong codes, leave, return and enter
    bus.arrival = 2'b01;
    expect_at(1, o(2'b01, 0, 0, 0, 0));
    tick();
    expect_at(1, o(2'b01, 0, 1, 0, 0));
    expect_at(2, o(2'b01, 0, 0, 0, 0));
    ack_code(0, 16'h1234);
    expect_at(1, o(2'b01, 0, 1, 0, 0));
    expect_at(2, o(2'b01, 0, 0, 0, 0));
    ack_code(0, 16'h3145);
    bus.arrival = 2'b00;
    expect_at(1, o(2'b00, 0, 0, 0, 0));
    tick(2);
    bus.arrival = 2'b01;
    expect_at(1, o(2'b01, 0, 0, 0, 0));
    tick();
    expect_at(1, o(2'b01, 1, 0, 0, 0));
    ack_code(0, 16'h5990);
    bus.arrival      = 2'b00;
    bus.vehicle_left = 1'b1;
    expect_at(1, o(2'b00, 0, 0, 0, 0));
    tick();
    bus.vehicle_left = 1'b0;
    tick(2);

    // Lockout after three wrong codes; correct code then ignored
    bus.arrival = 2'b01;
    expect_at(1, o(2'b01, 0, 0, 0, 0));
    tick();
    expect_at(1, o(2'b01, 0, 1, 0, 0));
    expect_at(2, o(2'b01, 0, 0, 0, 0));
    ack_code(0, 16'h1234);
    expect_at(1, o(2'b01, 0, 1, 0, 0));
    expect_at(2, o(2'b01, 0, 0, 0, 0));
    ack_code(0, 16'h3145);
    expect_at(1, o(2'b01, 0, 1, 1, 0));
    expect_at(2, o(2'b01, 0, 0, 1, 0));
    ack_code(0, 16'h4321);
    ack_code(0, 16'h5990);
    bus.arrival = 2'b00;
    tick(3);
    do_reset();

    // Tailgate: second car behind the one passing
    bus.arrival = 2'b01;
    expect_at(1, o(2'b01, 0, 0, 0, 0));
    tick();
    expect_at(1, o(2'b01, 1, 0, 0, 0));
    ack_code(0, 16'h5990);
    bus.vehicle_left = 1'b1;
    expect_at(1, o(2'b01, 0, 0, 0, 1));
    tick();
    bus.vehicle_left = 1'b0;
    bus.arrival      = 2'b00;
    tick(4);
    do_reset();

    // Arbitration with both lanes waiting, gate timeout, reset while open
    bus.arrival = 2'b11;
    expect_at(1, o(2'b01, 0, 0, 0, 0));
    tick();
    bus.code0       = 16'h5990;
    bus.code_ack[0] = 1'b1;
    expect_at(1, o(2'b01, 1, 0, 0, 0));
    expect_at(1 + GT, o(2'b00, 0, 0, 0, 0));
    expect_at(2 + GT, o(2'b10, 0, 0, 0, 0));
    tick();
    tick(GT + 2);
    bus.code1       = 16'h5990;
    bus.code_ack[1] = 1'b1;
    expect_at(1, o(2'b10, 1, 0, 0, 0));
    tick(3);
    do_reset();

    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_expect got=%0d left want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/parking_lane_arbiter.md
# parking_lane_arbiter

Entry-side controller that shares one gate and one PIN-check path between two entry lanes of the parking lot. It grants one lane at a time by round-robin, validates the granted lane's 16-bit code on each acknowledge, opens the gate on a match, and raises lockout or tailgate (block) alarms. It sits between the two lane keypads/presence sensors and the single gate actuator.

## Interface
- PASSWORD, 16'h5990, valid entry code
- MAX_TRIES, 3, consecutive wrong codes that lock the controller (range 1-15)
- GATE_TIMEOUT, 32, cycles the gate stays open without a pass before auto-close (≥2)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- arrival  input  2  per-lane vehicle-present level (bit i = lane i)
- code0  input  16  lane 0 entered code
- code1  input  16  lane 1 entered code
- code_ack  input  2  per-lane "code entered" level; rising edge = one attempt
- vehicle_left  input  1  gate-pass sensor level; rising edge = vehicle passed
- grant  output  2  one-hot lane being served; 2'b00 when none
- gate_open  output  1  gate actuator command
- pin_error  output  1  one-cycle pulse per wrong code
- lock_alarm  output  1  wrong-code lockout active
- block_alarm  output  1  tailgate alarm active

## Operation
- States: IDLE, SERVE, OPEN, LOCKED, BLOCK. Reset: state=IDLE, all outputs 0, attempt counter 0, timeout counter 0, round-robin pointer favours lane 0, code_ack history 2'b00, vehicle_left history 1.
- IDLE: if any arrival bit set, grant one lane, go SERVE. Both set: grant lane not served most recently (lane 0 after reset). grant is registered; stays 2'b00 otherwise.
- SERVE: rising edge of code_ack[g] (g = granted lane, edge = current 1, previous-cycle 0) compares code_g with PASSWORD in that cycle.
  - Match: attempts←0, go OPEN.
  - Mismatch: pin_error pulses; attempts+1; if attempts reaches MAX_TRIES, go LOCKED; else stay SERVE.
  - arrival[g] drops (no ack edge same cycle): attempts←0, grant←0, go IDLE, pointer updated to g.
  - code_ack edges on the non-granted lane are ignored (history still tracked).
- OPEN: gate_open=1, timeout counter increments each cycle.
  - Rising edge of vehicle_left with arrival[g]=0: gate_open←0, grant←0, go IDLE.
  - Rising edge of vehicle_left with arrival[g]=1 (second car behind): gate_open←0, go BLOCK.
  - Counter reaches GATE_TIMEOUT with no edge: gate_open←0, grant←0, go IDLE.
- LOCKED: lock_alarm=1, gate_open=0, grant held; all inputs ignored; exit only by rst.
- BLOCK: block_alarm=1, gate_open=0, grant held; exit only by rst.
- attempts persists across lane switches only when it is not cleared by the rules above; it is cleared on every transition to IDLE and on match.
- Simultaneous ack edge and arrival drop in SERVE: ack evaluated, arrival drop takes effect next cycle.

## Timing
- arrival rise in cycle N (state IDLE) → grant valid cycle N+1.
- code_ack[g] rise sampled at edge N → gate_open=1 or pin_error=1 at N+1; pin_error low at N+2.
- MAX_TRIES-th wrong code at N → pin_error and lock_alarm both 1 at N+1.
- OPEN entered at N → auto-close at N+GATE_TIMEOUT (gate_open 0 from that cycle).
- vehicle_left rise sampled at N in OPEN → gate_open=0 at N+1.
- rst assertion at any time, mid-transaction included → all outputs 0 immediately, state IDLE; held ack/vehicle_left levels after release produce no spurious edges if already high (ack history reset 0 is the exception: ack held high across reset counts as an edge).

## Test plan
- Basic entry: arrival=2'b01, code0=16'h5990, ack0 rise → grant=01 one cycle after arrival, gate_open=1; vehicle_left rise with arrival=0 → gate_open=0, grant=00.
- Wrong codes <MAX_TRIES: lane 0 codes 16'h1234 then 16'h3145 → two pin_error pulses, lock_alarm=0; arrival drop → IDLE, next correct code opens gate.
- Lockout: codes 16'h1234, 16'h3145, 16'h4321 → third pin_error with lock_alarm=1; further 16'h5990 ack ignored; rst low → lock_alarm=0.
- Tailgate: correct code, then vehicle_left rise while arrival[g]=1 → block_alarm=1, gate_open=0 until rst.
- Arbitration: arrival=2'b11 from reset → grant=01; after lane 0 completes with arrival still 2'b11 → grant=10.
- Timeout and reset: correct code, no vehicle_left → gate_open falls exactly GATE_TIMEOUT cycles after opening; rst low while in OPEN → all outputs 0 asynchronously.
